chimera_reg_to_apb: RTL and testbench
=====================================

// Module: chimera_reg_to_apb
// PURPOSE
// - Bridge from the 32-bit register-bus master port to APB slaves. Sits downstream of the SoC regbus demux.
// - Decodes the address onto NumApbSlv select lines. Default slaves: pad config (0x3000_2000-0x3000_3000) and FLL config (0x3000_3000-0x3000_4000).
// - Runs APB3/4 SETUP/ACCESS phases and returns the APB response, with a PREADY timeout guard.
// PARAMETERS
// - AddrWidth     32          regbus/APB address width
// - DataWidth     32          data width; only 32 is supported
// - NumApbSlv     2           number of APB slaves / psel lines
// - RegionStart   {PadRegionStart, FllRegionStart}   per-slave base address, inclusive
// - RegionEnd     {PadRegionEnd, FllRegionEnd}       per-slave end address, exclusive
// - TimeoutCycles 255         max ACCESS cycles before forced error; 0 disables the timeout
// PORTS
// - clk_i        in   1              clock
// - rst_i        in   1              asynchronous, active-high reset
// - reg_valid_i  in   1              regbus request valid
// - reg_addr_i   in   AddrWidth      request address
// - reg_write_i  in   1              1=write, 0=read
// - reg_wdata_i  in   DataWidth      write data
// - reg_wstrb_i  in   DataWidth/8    write byte strobes
// - reg_ready_o  out  1              response valid (single-cycle pulse)
// - reg_rdata_o  out  DataWidth      read data
// - reg_error_o  out  1              error response
// - paddr_o      out  AddrWidth      APB address (full, not offset)
// - psel_o       out  NumApbSlv      one-hot slave select
// - penable_o    out  1              APB enable
// - pwrite_o     out  1              APB write
// - pwdata_o     out  DataWidth      APB write data
// - pstrb_o      out  DataWidth/8    APB strobes
// - pprot_o      out  3              fixed 3'b000
// - prdata_i     in   NumApbSlv x DataWidth   per-slave read data
// - pready_i     in   NumApbSlv      per-slave ready
// - pslverr_i    in   NumApbSlv      per-slave error
// BEHAVIOUR
// - Reset: FSM=IDLE, timeout counter=0, every output 0.
// - All APB outputs and reg_* outputs are registered.
// - States: IDLE, SETUP, ACCESS, RESP.
// - IDLE, reg_valid_i=1:
//   - Latch addr, write, wdata, wstrb.
//   - Decode hit on slave i -> SETUP, drive psel_o[i]. Hit condition: RegionStart[i] <= addr < RegionEnd[i].
//   - Miss -> RESP with error=1, rdata=0. No APB activity.
// - SETUP: psel=1, penable=0 for exactly one cycle -> ACCESS.
// - ACCESS:
//   - psel=1, penable=1; paddr/pwrite/pwdata/pstrb held stable.
//   - Counter increments each ACCESS cycle.
//   - pready_i[i]=1 -> capture rdata = write ? 0 : prdata_i[i], and error = pslverr_i[i]. Go to RESP; psel/penable drop next cycle.
//   - Counter reaches TimeoutCycles without pready -> RESP with error=1, rdata=0. psel/penable deassert.
// - RESP:
//   - reg_ready_o=1 for one cycle with registered rdata/error -> IDLE. Counter clears.
//   - reg_rdata_o/reg_error_o are 0 whenever reg_ready_o=0.
// - Latency (valid at cycle T, IDLE):
//   - Decode miss: ready at T+2.
//   - Hit, zero-wait slave: SETUP T+1, ACCESS T+2, ready T+3. Each APB wait state adds 1.
// - Handshake:
//   - Requester holds valid/addr/data stable until ready. The bridge ignores changes after latching.
//   - reg_valid_i seen in the RESP cycle is not accepted. The next request is sampled in IDLE (no back-to-back accept).
// - Only the selected slave's pready/pslverr/prdata are observed. Others are ignored.
// - Overlapping regions: the lowest index wins.
// - Reset mid-transfer: psel/penable drop immediately (async). The transfer is abandoned and no response is issued.
// STRUCTURE
// - Add to chimera_pkg: ApbPadIdx=0, ApbFllIdx=1, NumApbSlv.
// - Add to chimera_pkg: apb_rule_t {idx, start_addr, end_addr} and the default rule array built from the Pad/FLL region constants.
// - Reuse the package apb_req_t/apb_resp_t for the bench.
// - One sub-module: the common_cells addr_decode instance (NoIndices=NumApbSlv). Outputs are a hit index and a miss flag.
// - Counter width: $clog2(TimeoutCycles+1).
// TESTING
// - Read 0x3000_2004, pad slave pready=1 immediately, prdata=0xCAFE_0001 -> psel_o=2'b01; reg_ready at T+3 with rdata=0xCAFE_0001, error=0.
// - Write 0x3000_3010, wdata=0x1234_5678, wstrb=4'b0011, FLL slave with 3 wait states -> psel_o=2'b10, pstrb=4'b0011, penable high 4 cycles; ready at T+6, rdata=0.
// - Read 0x3000_5000 (miss) -> no psel; ready at T+2 with error=1, rdata=0.
// - Pad slave responds pslverr=1 with prdata=0xDEAD_BEEF on a read -> error=1, rdata=0xDEAD_BEEF.
// - TimeoutCycles=255, pready held 0 -> psel drops after 255 ACCESS cycles; error=1, rdata=0. A following request completes normally.
// - rst_i asserted in ACCESS -> psel/penable 0 the same cycle, no reg_ready. After release, a read to 0x3000_2000 completes in 3 cycles.

Source files
------------

// File: rtl/chimera_pkg.sv
// Chimera SoC shared definitions: APB slave map, decode rules and APB bus structs.
package chimera_pkg;

  localparam int unsigned NumApbSlv = 2;
  localparam int unsigned ApbPadIdx = 0;
  localparam int unsigned ApbFllIdx = 1;

  localparam logic [31:0] PadRegionStart = 32'h3000_2000;
  localparam logic [31:0] PadRegionEnd   = 32'h3000_3000;
  localparam logic [31:0] FllRegionStart = 32'h3000_3000;
  localparam logic [31:0] FllRegionEnd   = 32'h3000_4000;

  // end_addr is exclusive
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } apb_rule_t;

  localparam apb_rule_t ApbRules [NumApbSlv] = '{
    '{idx: ApbPadIdx, start_addr: PadRegionStart, end_addr: PadRegionEnd},
    '{idx: ApbFllIdx, start_addr: FllRegionStart, end_addr: FllRegionEnd}
  };

  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;

endpackage

// File: rtl/chimera_reg_to_apb_addr_decode.sv
// Address-to-slave decoder: returns the index of the lowest-positioned matching rule, or a miss.
module chimera_reg_to_apb_addr_decode
  import chimera_pkg::*;
#(
  parameter int unsigned NoIndices = 2,
  parameter int unsigned NoRules   = NoIndices
) (
  input  logic [31:0] i_addr,
  input  apb_rule_t   i_rules [NoRules],
  output logic [31:0] o_idx,
  output logic        o_miss
);

  // Walk from the top so the lowest matching rule is the one left standing.
  always_comb begin
    o_idx  = '0;
    o_miss = 1'b1;
    for (int r = int'(NoRules) - 1; r >= 0; r--) begin
      if (i_addr >= i_rules[r].start_addr && i_addr < i_rules[r].end_addr &&
          i_rules[r].idx < NoIndices) begin
        o_idx  = i_rules[r].idx;
        o_miss = 1'b0;
      end
    end
  end

endmodule

// File: rtl/chimera_reg_to_apb.sv
// Register-bus to APB bridge: decodes onto NumApbSlv selects, runs SETUP/ACCESS, guards PREADY with a timeout.
module chimera_reg_to_apb
  import chimera_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned NumApbSlv     = chimera_pkg::NumApbSlv,
  parameter logic [AddrWidth-1:0] RegionStart [NumApbSlv] = '{PadRegionStart, FllRegionStart},
  parameter logic [AddrWidth-1:0] RegionEnd   [NumApbSlv] = '{PadRegionEnd, FllRegionEnd},
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              reg_valid_i,
  input  logic [AddrWidth-1:0]              reg_addr_i,
  input  logic                              reg_write_i,
  input  logic [DataWidth-1:0]              reg_wdata_i,
  input  logic [DataWidth/8-1:0]            reg_wstrb_i,
  output logic                              reg_ready_o,
  output logic [DataWidth-1:0]              reg_rdata_o,
  output logic                              reg_error_o,
  output logic [AddrWidth-1:0]              paddr_o,
  output logic [NumApbSlv-1:0]              psel_o,
  output logic                              penable_o,
  output logic                              pwrite_o,
  output logic [DataWidth-1:0]              pwdata_o,
  output logic [DataWidth/8-1:0]            pstrb_o,
  output logic [2:0]                        pprot_o,
  input  logic [NumApbSlv-1:0][DataWidth-1:0] prdata_i,
  input  logic [NumApbSlv-1:0]              pready_i,
  input  logic [NumApbSlv-1:0]              pslverr_i
);

  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]             r_state;
  logic [CntW-1:0]        r_cnt;
  logic [NumApbSlv-1:0]   r_psel;
  logic                   r_penable;
  logic [AddrWidth-1:0]   r_paddr;
  logic                   r_pwrite;
  logic [DataWidth-1:0]   r_pwdata;
  logic [DataWidth/8-1:0] r_pstrb;
  logic                   r_ready;
  logic [DataWidth-1:0]   r_rdata;
  logic                   r_error;

  apb_rule_t              w_rules [NumApbSlv];
  logic [31:0]            w_idx;
  logic                   w_miss;
  logic [NumApbSlv-1:0]   w_sel;
  logic [DataWidth-1:0]   w_prdata;
  logic                   w_pready;
  logic                   w_pslverr;

  for (genvar g = 0; g < NumApbSlv; g++) begin : g_rule
    assign w_rules[g] = '{idx: 32'(g), start_addr: 32'(RegionStart[g]), end_addr: 32'(RegionEnd[g])};
  end

  chimera_reg_to_apb_addr_decode #(
    .NoIndices (NumApbSlv),
    .NoRules   (NumApbSlv)
  ) u_addr_decode (
    .i_addr  (32'(reg_addr_i)),
    .i_rules (w_rules),
    .o_idx   (w_idx),
    .o_miss  (w_miss)
  );

  // The registered one-hot select doubles as the response mux, so unselected slaves are never seen.
  always_comb begin
    w_sel    = '0;
    w_prdata = '0;
    for (int i = 0; i < int'(NumApbSlv); i++) begin
      w_sel[i] = (w_idx == 32'(i));
      if (r_psel[i]) w_prdata |= prdata_i[i];
    end
  end

  assign w_pready  = |(pready_i & r_psel);
  assign w_pslverr = |(pslverr_i & r_psel);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_ready   <= 1'b0;
      r_rdata   <= '0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (reg_valid_i) begin
          r_paddr  <= reg_addr_i;
          r_pwrite <= reg_write_i;
          r_pwdata <= reg_wdata_i;
          r_pstrb  <= reg_wstrb_i;
          if (w_miss) begin
            r_state <= S_RESP;
          end else begin
            r_psel  <= w_sel;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_pready) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_ready   <= 1'b1;
            r_rdata   <= r_pwrite ? '0 : w_prdata;
            r_error   <= w_pslverr;
            r_state   <= S_RESP;
          end else if (TimeoutCycles != 0 && r_cnt == CntLast) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_ready   <= 1'b1;
            r_rdata   <= '0;
            r_error   <= 1'b1;
            r_state   <= S_RESP;
          end
        end
        default: begin
          // Arriving without a pending ready means a decode miss: spend this cycle raising the error.
          if (r_ready) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_error <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_ready <= 1'b1;
            r_rdata <= '0;
            r_error <= 1'b1;
          end
        end
      endcase
    end
  end

  assign reg_ready_o = r_ready;
  assign reg_rdata_o = r_rdata;
  assign reg_error_o = r_error;
  assign paddr_o     = r_paddr;
  assign psel_o      = r_psel;
  assign penable_o   = r_penable;
  assign pwrite_o    = r_pwrite;
  assign pwdata_o    = r_pwdata;
  assign pstrb_o     = r_pstrb;
  assign pprot_o     = 3'b000;

endmodule

// File: tb/tb_chimera_reg_to_apb.sv
// Directed bench for chimera_reg_to_apb with a cycle-counting APB slave model per select line.
module tb_chimera_reg_to_apb;
  import chimera_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              reg_valid;
  logic [31:0]       reg_addr;
  logic              reg_write;
  logic [31:0]       reg_wdata;
  logic [3:0]        reg_wstrb;
  logic              reg_ready;
  logic [31:0]       reg_rdata;
  logic              reg_error;
  logic [31:0]       paddr;
  logic [1:0]        psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [2:0]        pprot;
  logic [1:0][31:0]  prdata;
  logic [1:0]        pready;
  logic [1:0]        pslverr;

  apb_resp_t slv [2];
  int        waits [2];
  int        acc_cnt;
  int        total = 0;
  int        bad   = 0;

  always #5 clk = ~clk;

  chimera_reg_to_apb dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .reg_valid_i (reg_valid),
    .reg_addr_i  (reg_addr),
    .reg_write_i (reg_write),
    .reg_wdata_i (reg_wdata),
    .reg_wstrb_i (reg_wstrb),
    .reg_ready_o (reg_ready),
    .reg_rdata_o (reg_rdata),
    .reg_error_o (reg_error),
    .paddr_o     (paddr),
    .psel_o      (psel),
    .penable_o   (penable),
    .pwrite_o    (pwrite),
    .pwdata_o    (pwdata),
    .pstrb_o     (pstrb),
    .pprot_o     (pprot),
    .prdata_i    (prdata),
    .pready_i    (pready),
    .pslverr_i   (pslverr)
  );

  // Slave i answers after waits[i] stalled ACCESS cycles.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      pready[i]  = psel[i] & penable & (acc_cnt == waits[i]);
      prdata[i]  = slv[i].prdata;
      pslverr[i] = slv[i].pslverr;
    end
  end

  always @(posedge clk) begin
    if (penable && !(|pready)) acc_cnt <= acc_cnt + 1;
    else                       acc_cnt <= 0;
  end

  task automatic run_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input int budget,
                         output int lat, output logic [31:0] rd, output logic er,
                         output logic [1:0] psel_or, output int pen_cyc,
                         output logic [31:0] pa, output logic [3:0] ps,
                         output logic [31:0] pwd, output logic pw, output int idle_bad);
    @(negedge clk);
    reg_valid = 1'b1; reg_addr = a; reg_write = w; reg_wdata = d; reg_wstrb = s;
    lat = -1; rd = 'x; er = 1'bx; psel_or = '0; pen_cyc = 0;
    pa = '0; ps = '0; pwd = '0; pw = 1'b0; idle_bad = 0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (psel != 2'b00) begin
        psel_or |= psel; pa = paddr; ps = pstrb; pwd = pwdata; pw = pwrite;
      end
      if (penable) pen_cyc++;
      if (reg_ready) begin
        lat = n; rd = reg_rdata; er = reg_error;
        break;
      end else if (reg_rdata !== 32'h0 || reg_error !== 1'b0) begin
        idle_bad++;
      end
    end
    reg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reg_valid = 1'b0; reg_addr = '0; reg_write = 1'b0; reg_wdata = '0; reg_wstrb = '0;
    for (int i = 0; i < 2; i++) begin
      slv[i] = '0;
      waits[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({reg_ready, reg_rdata, reg_error} !== 34'h0) begin
      bad++; $display("FAIL reset_reg got=%h exp=0", {reg_ready, reg_rdata, reg_error});
    end
    total++;
    if ({paddr, psel, penable, pwrite, pwdata, pstrb, pprot} !== 75'h0) begin
      bad++; $display("FAIL reset_apb got=%h exp=0", {paddr, psel, penable, pwrite, pwdata, pstrb, pprot});
    end
    rst = 1'b0;
  endtask

  task automatic test_read_pad();
    int lat, pen, ib; logic [31:0] rd, pa, pwd; logic er, pw; logic [1:0] so; logic [3:0] ps;
    slv[0].prdata = 32'hCAFE_0001; slv[0].pslverr = 1'b0; waits[0] = 0;
    slv[1].prdata = 32'h5555_AAAA;
    run_req(32'h3000_2004, 1'b0, 32'h0, 4'hF, 20, lat, rd, er, so, pen, pa, ps, pwd, pw, ib);
    total++; if (so !== 2'b01) begin bad++; $display("FAIL rd_psel got=%b exp=01", so); end
    total++; if (lat !== 3) begin bad++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    total++; if (rd !== 32'hCAFE_0001) begin bad++; $display("FAIL rd_data got=%h exp=cafe0001", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL rd_error got=%b exp=0", er); end
    total++; if (pa !== 32'h3000_2004) begin bad++; $display("FAIL rd_paddr got=%h exp=30002004", pa); end
    total++; if (pen !== 1) begin bad++; $display("FAIL rd_penable_cycles got=%0d exp=1", pen); end
    total++; if (ib !== 0) begin bad++; $display("FAIL rd_idle_outputs got=%0d exp=0", ib); end
  endtask

  task automatic test_write_fll();
    int lat, pen, ib; logic [31:0] rd, pa, pwd; logic er, pw; logic [1:0] so; logic [3:0] ps;
    slv[1].prdata = 32'hFFFF_FFFF; slv[1].pslverr = 1'b0; waits[1] = 3;
    run_req(32'h3000_3010, 1'b1, 32'h1234_5678, 4'b0011, 20, lat, rd, er, so, pen, pa, ps, pwd, pw, ib);
    total++; if (so !== 2'b10) begin bad++; $display("FAIL wr_psel got=%b exp=10", so); end
    total++; if (ps !== 4'b0011) begin bad++; $display("FAIL wr_pstrb got=%b exp=0011", ps); end
    total++; if (pwd !== 32'h1234_5678 || pw !== 1'b1) begin
      bad++; $display("FAIL wr_pwdata got=%h/%b exp=12345678/1", pwd, pw);
    end
    total++; if (pen !== 4) begin bad++; $display("FAIL wr_penable_cycles got=%0d exp=4", pen); end
    total++; if (lat !== 6) begin bad++; $display("FAIL wr_latency got=%0d exp=6", lat); end
    total++; if (rd !== 32'h0 || er !== 1'b0) begin
      bad++; $display("FAIL wr_resp got=%h/%b exp=0/0", rd, er);
    end
    waits[1] = 0;
  endtask

  task automatic test_miss();
    int lat, pen, ib; logic [31:0] rd, pa, pwd; logic er, pw; logic [1:0] so; logic [3:0] ps;
    run_req(32'h3000_5000, 1'b0, 32'h0, 4'hF, 20, lat, rd, er, so, pen, pa, ps, pwd, pw, ib);
    total++; if (so !== 2'b00 || pen !== 0) begin
      bad++; $display("FAIL miss_apb psel=%b pen=%0d exp=00/0", so, pen);
    end
    total++; if (lat !== 2) begin bad++; $display("FAIL miss_latency got=%0d exp=2", lat); end
    total++; if (er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL miss_resp got=%h/%b exp=0/1", rd, er);
    end
    total++; if (ib !== 0) begin bad++; $display("FAIL miss_idle_outputs got=%0d exp=0", ib); end
  endtask

  task automatic test_slverr();
    int lat, pen, ib; logic [31:0] rd, pa, pwd; logic er, pw; logic [1:0] so; logic [3:0] ps;
    slv[0].prdata = 32'hDEAD_BEEF; slv[0].pslverr = 1'b1; waits[0] = 0;
    run_req(32'h3000_2100, 1'b0, 32'h0, 4'hF, 20, lat, rd, er, so, pen, pa, ps, pwd, pw, ib);
    total++; if (er !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL slverr_resp got=%h/%b exp=deadbeef/1", rd, er);
    end
    total++; if (lat !== 3) begin bad++; $display("FAIL slverr_latency got=%0d exp=3", lat); end
    slv[0].pslverr = 1'b0;
  endtask

  task automatic test_decode_bounds();
    logic [31:0] ta [5] = '{32'h3000_2FFC, 32'h3000_3000, 32'h3000_3FFC, 32'h3000_1FFC, 32'h3000_4000};
    logic [1:0]  ts [5] = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
    int          tl [5] = '{3, 3, 3, 2, 2};
    logic [31:0] td [5] = '{32'h1111_0000, 32'h2222_0000, 32'h2222_0000, 32'h0, 32'h0};
    logic        te [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat, pen, ib; logic [31:0] rd, pa, pwd; logic er, pw; logic [1:0] so; logic [3:0] ps;
    slv[0].prdata = 32'h1111_0000; slv[1].prdata = 32'h2222_0000;
    waits[0] = 0; waits[1] = 0;
    for (int k = 0; k < 5; k++) begin
      run_req(ta[k], 1'b0, 32'h0, 4'hF, 20, lat, rd, er, so, pen, pa, ps, pwd, pw, ib);
      total++;
      if (so !== ts[k] || lat !== tl[k] || rd !== td[k] || er !== te[k]) begin
        bad++;
        $display("FAIL bound_%h got psel=%b lat=%0d rd=%h er=%b exp psel=%b lat=%0d rd=%h er=%b",
                 ta[k], so, lat, rd, er, ts[k], tl[k], td[k], te[k]);
      end
    end
  endtask

  task automatic test_timeout();
    int lat, pen, ib; logic [31:0] rd, pa, pwd; logic er, pw; logic [1:0] so; logic [3:0] ps;
    waits[0] = 100000; slv[0].prdata = 32'hBAD0_BAD0;
    run_req(32'h3000_2008, 1'b0, 32'h0, 4'hF, 400, lat, rd, er, so, pen, pa, ps, pwd, pw, ib);
    total++; if (pen !== 255) begin bad++; $display("FAIL to_access_cycles got=%0d exp=255", pen); end
    total++; if (lat !== 257) begin bad++; $display("FAIL to_latency got=%0d exp=257", lat); end
    total++; if (er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL to_resp got=%h/%b exp=0/1", rd, er);
    end
    waits[0] = 0; slv[0].prdata = 32'h0BAD_F00D;
    run_req(32'h3000_200C, 1'b0, 32'h0, 4'hF, 20, lat, rd, er, so, pen, pa, ps, pwd, pw, ib);
    total++; if (lat !== 3 || rd !== 32'h0BAD_F00D || er !== 1'b0) begin
      bad++; $display("FAIL to_recover got lat=%0d rd=%h er=%b exp 3/0badf00d/0", lat, rd, er);
    end
  endtask

  task automatic test_reset_mid();
    int lat, pen, ib, rdy_seen; logic [31:0] rd, pa, pwd; logic er, pw; logic [1:0] so; logic [3:0] ps;
    waits[0] = 100000;
    @(negedge clk);
    reg_valid = 1'b1; reg_addr = 32'h3000_2000; reg_write = 1'b0; reg_wstrb = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (psel !== 2'b01 || penable !== 1'b1) begin
      bad++; $display("FAIL rm_in_access psel=%b pen=%b exp=01/1", psel, penable);
    end
    #1 rst = 1'b1;
    #1;
    total++; if (psel !== 2'b00 || penable !== 1'b0) begin
      bad++; $display("FAIL rm_async_drop psel=%b pen=%b exp=00/0", psel, penable);
    end
    reg_valid = 1'b0;
    rdy_seen = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (reg_ready !== 1'b0) rdy_seen++;
    end
    rst = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      if (reg_ready !== 1'b0) rdy_seen++;
    end
    total++; if (rdy_seen !== 0) begin bad++; $display("FAIL rm_no_ready got=%0d exp=0", rdy_seen); end
    waits[0] = 0; slv[0].prdata = 32'h7777_0123;
    run_req(32'h3000_2000, 1'b0, 32'h0, 4'hF, 20, lat, rd, er, so, pen, pa, ps, pwd, pw, ib);
    total++; if (lat !== 3 || rd !== 32'h7777_0123 || er !== 1'b0) begin
      bad++; $display("FAIL rm_after got lat=%0d rd=%h er=%b exp 3/77770123/0", lat, rd, er);
    end
  endtask

  initial begin
    test_reset();
    test_read_pad();
    test_write_fll();
    test_miss();
    test_slverr();
    test_decode_bounds();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog sim time exceeded total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
